// File: rtl/kw_ram_nr_1ws_dff.sv
// Flip-flop RAM: one synchronous byte-masked write port, NUM_RD_PORTS asynchronous read ports,
// word-per-cycle clear sweep. Define KW_RAM_WR_ERR_EN to add the sticky wr_err output.
module kw_ram_nr_1ws_dff #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int NUM_RD_PORTS = 2,
  parameter int BYTE_WIDTH   = 8,
  parameter int WRITE_BYPASS = 0,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int MASK_WIDTH   = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               cs_n,
  input  logic                               we_n,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [MASK_WIDTH-1:0]              wr_mask,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] data_out,
  output logic                               ready
`ifdef KW_RAM_WR_ERR_EN
  ,
  output logic                               wr_err
`endif
);

`ifndef SYNTHESIS
  if (DATA_WIDTH < 1 || DATA_WIDTH > 256 || DEPTH < 2 || DEPTH > 256 ||
      NUM_RD_PORTS < 1 || NUM_RD_PORTS > 8 ||
      BYTE_WIDTH < 1 || BYTE_WIDTH > DATA_WIDTH ||
      (DATA_WIDTH % BYTE_WIDTH) != 0 ||
      (WRITE_BYPASS != 0 && WRITE_BYPASS != 1)) begin : g_bad_params
    $fatal(1, "kw_ram_nr_1ws_dff: illegal parameter combination");
  end
`endif

  localparam int                    AW1       = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0]        DEPTH_X   = AW1'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_attempt;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] wr_word;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [MASK_WIDTH-1:0] mask);
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (mask[i]) r[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return r;
  endfunction

  // A user write lands only in IDLE; reset and clear both take priority over it.
  assign wr_attempt = !cs_n && !we_n;
  assign wr_ok      = wr_attempt && (state == IDLE) && !reset && !clear && in_range(wr_addr);
  assign wr_word    = merge_lanes(mem[wr_addr], data_in, wr_mask);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_ptr == LAST_ADDR) begin
            state   <= IDLE;
            clr_ptr <= '0;
            ready   <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
          end
        end
        IDLE: begin
          if (clear) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it one word per cycle.
  always_ff @(posedge clock) begin
    if (state == CLEAR && !reset) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_word;
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] raddr;
    raddr    = '0;
    data_out = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      raddr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      if (ready && in_range(raddr)) begin
        if (WRITE_BYPASS == 1 && wr_ok && raddr == wr_addr) begin
          data_out[p*DATA_WIDTH +: DATA_WIDTH] = wr_word;
        end else begin
          data_out[p*DATA_WIDTH +: DATA_WIDTH] = mem[raddr];
        end
      end
    end
  end

`ifdef KW_RAM_WR_ERR_EN
  // Sticky until reset: any attempted write that did not reach storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_err <= 1'b0;
    end else if (wr_attempt && (state == CLEAR || clear || !in_range(wr_addr))) begin
      wr_err <= 1'b1;
    end
  end
`endif

endmodule
